rocca_s_hw_v2_axis_stall_detector: RTL and testbench
====================================================

ROCCA_S_HW_V2_AXIS_STALL_DETECTOR -- requirements
Module: rocca_s_hw_v2_axis_stall_detector

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 5, the number of monitored AXI-Stream channels (1..16).
REQ-002 The block SHALL have parameter STALL_THRESH, default 1024, the consecutive stalled cycles before a channel is flagged (1..65535).
REQ-003 The block SHALL have parameter CNT_W, default 16, the stall counter width; it SHALL satisfy 2^CNT_W > STALL_THRESH.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  monitoring enable; low forces all channels to CLEAR.
REQ-007 clear  input  1  one-cycle pulse; clears the sticky status.
REQ-008 tvalid  input  NUM_CH  per-channel TVALID sampled from the monitored streams.
REQ-009 tready  input  NUM_CH  per-channel TREADY sampled from the monitored streams.
REQ-010 axis_block_sigs  output  NUM_CH  registered per-channel block flags, consumed by the deadlock monitor.
REQ-011 any_block  output  1  registered OR of axis_block_sigs.
REQ-012 stall_seen  output  1  sticky flag: some channel reached BLOCKED since the last clear.
REQ-013 first_ch  output  4  index of the first channel to reach BLOCKED since the last clear.

Function
REQ-014 Channel i SHALL be stalled in a cycle when tvalid[i]=1 and tready[i]=0.
REQ-015 Each channel SHALL run its own FSM with the states CLEAR, COUNTING and BLOCKED.
REQ-016 CLEAR SHALL move to COUNTING with the count set to 1 when stalled and enable=1; otherwise it SHALL stay in CLEAR.
REQ-017 COUNTING SHALL increment the count while stalled, and SHALL move to BLOCKED when the count reaches STALL_THRESH.
REQ-018 COUNTING or BLOCKED SHALL return to CLEAR with the count at 0 in any cycle the channel is not stalled (handshake, or tvalid dropped).
REQ-019 The count SHALL saturate at STALL_THRESH and SHALL never wrap.
REQ-020 axis_block_sigs[i] SHALL be 1 exactly while channel i is in BLOCKED.
REQ-021 Latency: with a stall sampled on edges 1..STALL_THRESH, axis_block_sigs[i] SHALL be high immediately after edge STALL_THRESH.
REQ-022 With STALL_THRESH=1, axis_block_sigs[i] SHALL rise after the first stalled edge.
REQ-023 axis_block_sigs[i] SHALL fall one edge after the first non-stalled sample.
REQ-024 enable=0 SHALL force all channels to CLEAR on the next edge and SHALL leave stall_seen and first_ch unchanged.
REQ-025 stall_seen SHALL set on the edge at which any channel enters BLOCKED, and first_ch SHALL capture that channel's index only when stall_seen was 0.
REQ-026 If several channels enter BLOCKED on the same edge, first_ch SHALL take the lowest index.
REQ-027 clear SHALL reset stall_seen to 0 and first_ch to 0, unless a channel enters BLOCKED on the same edge; in that case stall_seen SHALL be 1 and first_ch SHALL be that channel (new event wins).
REQ-028 clear SHALL NOT affect the channel FSMs or axis_block_sigs.

Reset
REQ-029 Asserting reset SHALL immediately force all FSMs to CLEAR, all counts to 0, and axis_block_sigs, any_block, stall_seen and first_ch to 0, independent of clock.
REQ-030 Reset asserted mid-count SHALL discard the partial count; counting SHALL restart from 1 at the first stalled edge after deassertion.

Structure
REQ-031 A shared package SHALL hold the channel-state enum (CLEAR, COUNTING, BLOCKED), the default NUM_CH, STALL_THRESH and CNT_W, and the first_ch width constant.
REQ-032 One sub-module, rocca_s_hw_v2_axis_stall_chan, SHALL implement one channel (FSM, counter, block flag), be instantiated NUM_CH times by generate, and the top SHALL contain only the sticky and priority logic.

Verification
REQ-033 STALL_THRESH=4, ch2 tvalid=1 and tready=0 held: axis_block_sigs=5'b00100 after edge 4 (not before), stall_seen=1, first_ch=2.
REQ-034 ch0 stalled 3 cycles, then tready=1 for 1 cycle, then stalled 4 cycles (STALL_THRESH=4): the block flag asserts only after edge 4 of the second stall run.
REQ-035 ch1 and ch3 stall starting on the same edge: both flags rise together and first_ch=1; after clear, with ch4 later blocked, first_ch=4.
REQ-036 Stall held 10000 cycles with STALL_THRESH=1024: the count holds at 1024, with no wrap and no flag glitch; releasing tvalid drops the flag one edge later.
REQ-037 reset pulsed asynchronously mid-count and mid-BLOCKED: all outputs read 0 before the next clock edge; counting resumes from 1 afterwards.
REQ-038 clear pulsed on the same edge a channel enters BLOCKED: stall_seen=1 and first_ch equals that channel; enable=0 drops axis_block_sigs within one edge while stall_seen holds.

Source files
------------

// File: rtl/rocca_s_hw_v2_axis_stall_detector_pkg.sv
// Shared definitions for the AXI-Stream stall detector.
// Holds the per-channel state encoding, the default parameter values
// and the width of the first_ch index output.
package rocca_s_hw_v2_axis_stall_detector_pkg;

    localparam int DEF_NUM_CH       = 5;
    localparam int DEF_STALL_THRESH = 1024;
    localparam int DEF_CNT_W        = 16;
    localparam int FIRST_CH_W       = 4;

    typedef enum logic [1:0] {
        CLEAR    = 2'd0,
        COUNTING = 2'd1,
        BLOCKED  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/rocca_s_hw_v2_axis_stall_chan.sv
// One monitored AXI-Stream channel: stall FSM, saturating stall counter
// and the registered block flag.
//
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   enable        low forces the channel back to CLEAR on the next edge
//   tvalid/tready sampled handshake of the monitored stream
//   block         registered flag, high exactly while in BLOCKED
//   block_next    value block takes on the coming edge
//   enter_block   high in the cycle before the edge that enters BLOCKED
//
// Handshake semantics: a beat transfers when tvalid=1 and tready=1; the
// channel is stalled when tvalid=1 and tready=0. An idle stream
// (tvalid=0) is never a stall.
module rocca_s_hw_v2_axis_stall_chan
    import rocca_s_hw_v2_axis_stall_detector_pkg::*;
#(
    parameter int STALL_THRESH = DEF_STALL_THRESH,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic tvalid,
    input  logic tready,
    output logic block,
    output logic block_next,
    output logic enter_block
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    ch_state_e        state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             active;

    // A stall only counts while monitoring is enabled.
    assign active = enable & tvalid & ~tready;

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            CLEAR: begin
                if (active) begin
                    count_next = ONE;
                    // A threshold of one blocks on the very first stalled edge.
                    state_next = (THRESH == ONE) ? BLOCKED : COUNTING;
                end
            end
            COUNTING: begin
                if (!active) begin
                    state_next = CLEAR;
                    count_next = '0;
                end else begin
                    count_next = count + ONE;
                    if (count == THRESH - ONE) begin
                        state_next = BLOCKED;
                    end
                end
            end
            BLOCKED: begin
                // Count stays at THRESH here, so it saturates instead of wrapping.
                if (!active) begin
                    state_next = CLEAR;
                    count_next = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                count_next = '0;
            end
        endcase
    end

    assign block_next  = (state_next == BLOCKED);
    assign enter_block = block_next & (state != BLOCKED);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            count <= '0;
            block <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            block <= block_next;
        end
    end

endmodule

// File: rtl/rocca_s_hw_v2_axis_stall_detector.sv
// Multi-channel AXI-Stream stall detector. Each channel is watched by its
// own stall FSM; this level adds the sticky "some channel blocked" status
// and records which channel blocked first since the last clear.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   enable           monitoring enable, low clears all channel FSMs
//   clear            one-cycle pulse clearing stall_seen / first_ch
//   tvalid, tready   per-channel handshake samples [NUM_CH]
//   axis_block_sigs  registered per-channel block flags [NUM_CH]
//   any_block        registered OR of the block flags
//   stall_seen       sticky: a channel entered BLOCKED since last clear
//   first_ch         index of the first channel to block since last clear
module rocca_s_hw_v2_axis_stall_detector
    import rocca_s_hw_v2_axis_stall_detector_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int STALL_THRESH = DEF_STALL_THRESH,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [NUM_CH-1:0]     tvalid,
    input  logic [NUM_CH-1:0]     tready,
    output logic [NUM_CH-1:0]     axis_block_sigs,
    output logic                  any_block,
    output logic                  stall_seen,
    output logic [FIRST_CH_W-1:0] first_ch
);

    logic [NUM_CH-1:0]     block_next;
    logic [NUM_CH-1:0]     enter_block;
    logic [FIRST_CH_W-1:0] lowest_enter;
    logic                  any_enter;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rocca_s_hw_v2_axis_stall_chan #(
            .STALL_THRESH (STALL_THRESH),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .enable      (enable),
            .tvalid      (tvalid[i]),
            .tready      (tready[i]),
            .block       (axis_block_sigs[i]),
            .block_next  (block_next[i]),
            .enter_block (enter_block[i])
        );
    end

    // Scan from the top down so the lowest entering index wins.
    always_comb begin
        lowest_enter = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (enter_block[i]) begin
                lowest_enter = FIRST_CH_W'(i);
            end
        end
    end

    assign any_enter = |enter_block;

    // any_block is registered from the channels' next-state flags so it
    // changes on the same edge as axis_block_sigs. A new blocking event
    // takes precedence over a simultaneous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            any_block  <= 1'b0;
            stall_seen <= 1'b0;
            first_ch   <= '0;
        end else begin
            any_block <= |block_next;
            if (any_enter) begin
                stall_seen <= 1'b1;
                if (!stall_seen || clear) begin
                    first_ch <= lowest_enter;
                end
            end else if (clear) begin
                stall_seen <= 1'b0;
                first_ch   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rocca_s_hw_v2_axis_stall_detector.sv
// Bench for the stall detector. Three instances share one stimulus stream
// with thresholds 4, 1024 and 1; a run-length reference model predicts
// the outputs of all three.
module tb_rocca_s_hw_v2_axis_stall_detector;

    localparam int NCH = 5;
    localparam int NI  = 3;
    localparam int THR [NI] = '{4, 1024, 1};

    logic           clock;
    logic           reset;
    logic           enable;
    logic           clear;
    logic [NCH-1:0] tvalid;
    logic [NCH-1:0] tready;

    logic [NCH-1:0] blk0, blk1, blk2;
    logic           any0, any1, any2;
    logic           seen0, seen1, seen2;
    logic [3:0]     first0, first1, first2;

    logic [NCH-1:0] blk_o   [NI];
    logic           any_o   [NI];
    logic           seen_o  [NI];
    logic [3:0]     first_o [NI];

    assign blk_o[0] = blk0;     assign blk_o[1] = blk1;     assign blk_o[2] = blk2;
    assign any_o[0] = any0;     assign any_o[1] = any1;     assign any_o[2] = any2;
    assign seen_o[0] = seen0;   assign seen_o[1] = seen1;   assign seen_o[2] = seen2;
    assign first_o[0] = first0; assign first_o[1] = first1; assign first_o[2] = first2;

    rocca_s_hw_v2_axis_stall_detector #(.NUM_CH(NCH), .STALL_THRESH(4), .CNT_W(16)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .tvalid(tvalid), .tready(tready), .axis_block_sigs(blk0),
        .any_block(any0), .stall_seen(seen0), .first_ch(first0));

    rocca_s_hw_v2_axis_stall_detector #(.NUM_CH(NCH), .STALL_THRESH(1024), .CNT_W(16)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .tvalid(tvalid), .tready(tready), .axis_block_sigs(blk1),
        .any_block(any1), .stall_seen(seen1), .first_ch(first1));

    rocca_s_hw_v2_axis_stall_detector #(.NUM_CH(NCH), .STALL_THRESH(1), .CNT_W(16)) dut2 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .tvalid(tvalid), .tready(tready), .axis_block_sigs(blk2),
        .any_block(any2), .stall_seen(seen2), .first_ch(first2));

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // run_m counts consecutive enabled stalled edges (capped at the threshold);
    // a channel is blocked whenever its run has reached the threshold.
    int             run_m   [NI][NCH];
    logic [NCH-1:0] blk_m   [NI];
    logic           seen_m  [NI];
    logic [3:0]     first_m [NI];

    int total = 0;
    int bad   = 0;

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < NCH; c++) run_m[k][c] = 0;
            blk_m[k]   = '0;
            seen_m[k]  = 1'b0;
            first_m[k] = 4'd0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            logic [NCH-1:0] nb;
            logic [NCH-1:0] ent;
            int low;
            nb = '0;
            for (int c = 0; c < NCH; c++) begin
                if (enable && tvalid[c] && !tready[c])
                    run_m[k][c] = (run_m[k][c] >= THR[k]) ? THR[k] : run_m[k][c] + 1;
                else
                    run_m[k][c] = 0;
                nb[c] = (run_m[k][c] >= THR[k]);
            end
            ent = nb & ~blk_m[k];
            blk_m[k] = nb;
            if (ent != '0) begin
                low = 0;
                for (int c = NCH - 1; c >= 0; c--) if (ent[c]) low = c;
                if (!seen_m[k] || clear) first_m[k] = 4'(low);
                seen_m[k] = 1'b1;
            end else if (clear) begin
                seen_m[k]  = 1'b0;
                first_m[k] = 4'd0;
            end
        end
    endtask

    // ---------------- driver ----------------
    // Model the edge with the inputs now applied, take the edge, and land
    // 1 time unit after it. clear is a single-cycle pulse.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    task automatic quiesce();
        tvalid = '0;
        tready = '0;
        enable = 1'b1;
        tick();
        clear = 1'b1;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            total++;
            if ({blk_o[k], any_o[k], seen_o[k], first_o[k]} !== 11'd0) begin
                bad++;
                $display("FAIL reset inst%0d: got %b want 0", k,
                         {blk_o[k], any_o[k], seen_o[k], first_o[k]});
            end
        end
    endtask

    task automatic test_single_ch2();
        enable = 1'b1;
        tvalid = 5'b00100;
        tready = 5'b00000;
        for (int n = 1; n <= 6; n++) begin
            tick();
            total++;
            if (blk_o[0] !== ((n >= 4) ? 5'b00100 : 5'b00000)) begin
                bad++;
                $display("FAIL single_ch2 edge%0d: got %b want %b", n, blk_o[0],
                         (n >= 4) ? 5'b00100 : 5'b00000);
            end
            for (int k = 0; k < NI; k++) begin
                total++;
                if ({blk_o[k], any_o[k], seen_o[k], first_o[k]} !==
                    {blk_m[k], |blk_m[k], seen_m[k], first_m[k]}) begin
                    bad++;
                    $display("FAIL single_ch2 model inst%0d edge%0d: got %b want %b", k, n,
                             {blk_o[k], any_o[k], seen_o[k], first_o[k]},
                             {blk_m[k], |blk_m[k], seen_m[k], first_m[k]});
                end
            end
        end
        total++;
        if ({seen_o[0], first_o[0]} !== {1'b1, 4'd2}) begin
            bad++;
            $display("FAIL single_ch2 sticky: got %b want %b", {seen_o[0], first_o[0]}, {1'b1, 4'd2});
        end
        quiesce();
    endtask

    task automatic test_restart();
        // 3 stalled edges, one handshake, then 4 stalled edges on ch0.
        for (int n = 1; n <= 8; n++) begin
            tvalid = 5'b00001;
            tready = (n == 4) ? 5'b00001 : 5'b00000;
            tick();
            total++;
            if (blk_o[0][0] !== (n == 8)) begin
                bad++;
                $display("FAIL restart edge%0d: got %b want %b", n, blk_o[0][0], (n == 8));
            end
            for (int k = 0; k < NI; k++) begin
                total++;
                if ({blk_o[k], any_o[k], seen_o[k], first_o[k]} !==
                    {blk_m[k], |blk_m[k], seen_m[k], first_m[k]}) begin
                    bad++;
                    $display("FAIL restart model inst%0d edge%0d: got %b want %b", k, n,
                             {blk_o[k], any_o[k], seen_o[k], first_o[k]},
                             {blk_m[k], |blk_m[k], seen_m[k], first_m[k]});
                end
            end
        end
        quiesce();
    endtask

    task automatic test_same_edge();
        tvalid = 5'b01010;
        tready = 5'b00000;
        for (int n = 1; n <= 4; n++) tick();
        total++;
        if ({blk_o[0], seen_o[0], first_o[0]} !== {5'b01010, 1'b1, 4'd1}) begin
            bad++;
            $display("FAIL same_edge: got %b want %b", {blk_o[0], seen_o[0], first_o[0]},
                     {5'b01010, 1'b1, 4'd1});
        end
        clear = 1'b1;
        tick();
        tvalid = 5'b11010;
        for (int n = 1; n <= 4; n++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                total++;
                if ({blk_o[k], any_o[k], seen_o[k], first_o[k]} !==
                    {blk_m[k], |blk_m[k], seen_m[k], first_m[k]}) begin
                    bad++;
                    $display("FAIL same_edge model inst%0d edge%0d: got %b want %b", k, n,
                             {blk_o[k], any_o[k], seen_o[k], first_o[k]},
                             {blk_m[k], |blk_m[k], seen_m[k], first_m[k]});
                end
            end
        end
        total++;
        if (first_o[0] !== 4'd4) begin
            bad++;
            $display("FAIL same_edge after clear: got %0d want 4", first_o[0]);
        end
        quiesce();
    endtask

    task automatic test_long_hold();
        tvalid = 5'b00001;
        tready = 5'b00000;
        for (int n = 1; n <= 10000; n++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                total++;
                if ({blk_o[k], any_o[k], seen_o[k], first_o[k]} !==
                    {blk_m[k], |blk_m[k], seen_m[k], first_m[k]}) begin
                    bad++;
                    $display("FAIL long_hold inst%0d edge%0d: got %b want %b", k, n,
                             {blk_o[k], any_o[k], seen_o[k], first_o[k]},
                             {blk_m[k], |blk_m[k], seen_m[k], first_m[k]});
                end
            end
        end
        total++;
        if (dut1.g_ch[0].u_chan.count !== 16'd1024) begin
            bad++;
            $display("FAIL long_hold count: got %0d want 1024", dut1.g_ch[0].u_chan.count);
        end
        total++;
        if (blk_o[1][0] !== 1'b1) begin
            bad++;
            $display("FAIL long_hold flag: got %b want 1", blk_o[1][0]);
        end
        tvalid = 5'b00000;
        tick();
        total++;
        if (blk_o[1][0] !== 1'b0) begin
            bad++;
            $display("FAIL long_hold release: got %b want 0", blk_o[1][0]);
        end
        quiesce();
    endtask

    task automatic test_async_reset();
        tvalid = 5'b00001;
        tready = 5'b00000;
        // Round 0: reset mid-count (inst0), round 1: reset while inst0 is BLOCKED.
        for (int r = 0; r < 2; r++) begin
            for (int n = 1; n <= ((r == 0) ? 2 : 5); n++) tick();
            #2;
            reset = 1'b1;
            #1;
            for (int k = 0; k < NI; k++) begin
                total++;
                if ({blk_o[k], any_o[k], seen_o[k], first_o[k]} !== 11'd0) begin
                    bad++;
                    $display("FAIL async_reset r%0d inst%0d: got %b want 0", r, k,
                             {blk_o[k], any_o[k], seen_o[k], first_o[k]});
                end
            end
            model_reset();
            #1;
            reset = 1'b0;
            for (int n = 1; n <= 4; n++) begin
                tick();
                total++;
                if (blk_o[0][0] !== (n == 4)) begin
                    bad++;
                    $display("FAIL async_reset resume r%0d edge%0d: got %b want %b", r, n,
                             blk_o[0][0], (n == 4));
                end
            end
        end
        quiesce();
    endtask

    task automatic test_clear_same_edge();
        tvalid = 5'b00001;
        tready = 5'b00000;
        for (int n = 1; n <= 4; n++) tick();
        tvalid = 5'b01001;
        for (int n = 1; n <= 3; n++) tick();
        clear = 1'b1;
        tick();
        total++;
        if ({seen_o[0], first_o[0]} !== {1'b1, 4'd3}) begin
            bad++;
            $display("FAIL clear_same_edge: got %b want %b", {seen_o[0], first_o[0]}, {1'b1, 4'd3});
        end
        enable = 1'b0;
        tick();
        total++;
        if ({blk_o[0], any_o[0], seen_o[0], first_o[0]} !== {5'b00000, 1'b0, 1'b1, 4'd3}) begin
            bad++;
            $display("FAIL disable: got %b want %b", {blk_o[0], any_o[0], seen_o[0], first_o[0]},
                     {5'b00000, 1'b0, 1'b1, 4'd3});
        end
        for (int k = 0; k < NI; k++) begin
            total++;
            if ({blk_o[k], any_o[k], seen_o[k], first_o[k]} !==
                {blk_m[k], |blk_m[k], seen_m[k], first_m[k]}) begin
                bad++;
                $display("FAIL disable model inst%0d: got %b want %b", k,
                         {blk_o[k], any_o[k], seen_o[k], first_o[k]},
                         {blk_m[k], |blk_m[k], seen_m[k], first_m[k]});
            end
        end
        quiesce();
    endtask

    task automatic test_random();
        for (int n = 1; n <= 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                tvalid[c] = ($urandom_range(0, 31) != 0);
                tready[c] = ($urandom_range(0, 15) == 0);
            end
            enable = ($urandom_range(0, 99) != 0);
            clear  = ($urandom_range(0, 49) == 0);
            tick();
            for (int k = 0; k < NI; k++) begin
                total++;
                if ({blk_o[k], any_o[k], seen_o[k], first_o[k]} !==
                    {blk_m[k], |blk_m[k], seen_m[k], first_m[k]}) begin
                    bad++;
                    $display("FAIL random inst%0d cyc%0d: got %b want %b", k, n,
                             {blk_o[k], any_o[k], seen_o[k], first_o[k]},
                             {blk_m[k], |blk_m[k], seen_m[k], first_m[k]});
                end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        clear  = 1'b0;
        tvalid = '0;
        tready = '0;
        model_reset();
        #12;
        test_reset();
        reset = 1'b0;
        tick();
        test_single_ch2();
        test_restart();
        test_same_edge();
        test_long_hold();
        test_async_reset();
        test_clear_same_edge();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
